div_seq_ctrl: RTL

//  Sequencer for the 8-bit non-restoring divider datapath. Accepts a divide request,

---
 rtl/div_ctrl_pkg.sv | 5 +
 rtl/div_seq_fsm.sv | 45 ++++
 rtl/div_seq_ctrl.sv | 64 ++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding and width for the divider sequencer
package div_ctrl_pkg;
  localparam int DIV_N_BITS = 8;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ADDSUB, FIX, DONE} div_state_t;
endpackage

// File: rtl/div_seq_fsm.sv
// div_seq_fsm: state register, next-state logic and datapath strobe decode
module div_seq_fsm
  import div_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       div_zero,
  input  logic       iter_first,
  input  logic       iter_last,
  input  logic       sign_q,
  input  logic       rem_sign,
  input  logic       result_ready,
  output div_state_t state,
  output div_state_t state_next,
  output logic       load,
  output logic       shift_en,
  output logic       add_en,
  output logic       sub_en,
  output logic       final_add,
  output logic       count_en
);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? (div_zero ? DONE : LOAD) : IDLE;
      LOAD:    state_next = SHIFT;
      SHIFT:   state_next = ADDSUB;
      ADDSUB:  state_next = iter_last ? FIX : SHIFT;
      FIX:     state_next = DONE;
      DONE:    state_next = result_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  // the first iteration always subtracts; afterwards the pre-shift sign picks add or sub
  assign load      = state == LOAD;
  assign shift_en  = state == SHIFT;
  assign count_en  = state == ADDSUB;
  assign sub_en    = count_en && (iter_first || !sign_q);
  assign add_en    = count_en && !iter_first && sign_q;
  assign final_add = (state == FIX) && rem_sign;
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencer for the non-restoring divider datapath
// owns operand latches, iteration count, sampled sign and result flags
module div_seq_ctrl
  import div_ctrl_pkg::*;
#(
  parameter  int N_BITS = DIV_N_BITS,
  localparam int ITER_W = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              start_ready,
  input  logic [N_BITS-1:0] dividend_in,
  input  logic [N_BITS-1:0] divisor_in,
  output logic [N_BITS-1:0] dividend_q,
  output logic [N_BITS-1:0] divisor_q,
  input  logic              rem_sign,
  output logic              load,
  output logic              shift_en,
  output logic              add_en,
  output logic              sub_en,
  output logic              final_add,
  output logic              count_en,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              div_by_zero
);
  div_state_t        state, state_next;
  logic [ITER_W-1:0] iter;
  logic              sign_q, iter_first, iter_last, div_zero;
  assign div_zero    = divisor_in == '0;
  assign iter_first  = iter == '0;
  assign iter_last   = iter == ITER_W'(N_BITS - 1);
  assign start_ready = state == IDLE;
  assign busy        = state inside {LOAD, SHIFT, ADDSUB, FIX};
  div_seq_fsm u_fsm (
    .clk(clk), .reset(reset), .start(start), .div_zero(div_zero),
    .iter_first(iter_first), .iter_last(iter_last), .sign_q(sign_q),
    .rem_sign(rem_sign), .result_ready(result_ready),
    .state(state), .state_next(state_next),
    .load(load), .shift_en(shift_en), .add_en(add_en), .sub_en(sub_en),
    .final_add(final_add), .count_en(count_en)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dividend_q   <= '0;
      divisor_q    <= '0;
      div_by_zero  <= 1'b0;
      iter         <= '0;
      sign_q       <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      if (start_ready && start) begin
        dividend_q  <= dividend_in;
        divisor_q   <= divisor_in;
        div_by_zero <= div_zero;
      end
      if (load) iter <= '0;
      else if (count_en && !iter_last) iter <= iter + 1'b1;
      if (shift_en) sign_q <= rem_sign;
      result_valid <= state_next == DONE;
    end
endmodule
